run_ctrl: RTL
=============

# run_ctrl

Run-control sequencer for the single-cycle core. Generates the one-cycle PC-update enable, `pc_en_o`, in place of a divided clock, so the PC register and all datapath state run on the board clock. Supports free-run at a prescaled rate, debounced single-step from a push button, and an optional PC breakpoint. Also keeps a retired-instruction counter for the 7-segment monitor.

## Interface
Parameters:
- DIV, 50_000_000: board-clock cycles per executed instruction in RUN; minimum 2.
- DEB_CYCLES, 1_000_000: consecutive stable cycles required to accept a step-button level.

Ports:
- clk_i  input  1  board clock; the only clock.
- rst_ni  input  1  reset, asynchronous and active-low.
- run_i  input  1  run switch, asynchronous; 1 requests free-run.
- step_i  input  1  raw step push button, asynchronous, active-high.
- brk_en_i  input  1  breakpoint enable; quasi-static.
- brk_addr_i  input  32  breakpoint PC; quasi-static.
- pc_i  input  32  current PC register value.
- pc_en_o  output  1  one-cycle pulse; the PC register and write-backs update only when it is 1.
- state_o  output  2  current FSM state, for LEDs.
- brk_hit_o  output  1  1 while in BRK.
- retired_o  output  32  count of `pc_en_o` pulses since reset.

## Operation
- `run_i` passes through a 2-FF synchronizer. `step_i` passes through a 2-FF synchronizer, then a debouncer, then a rising-edge detector, which produces the `step_p` pulse.
- Prescaler: counts 0..DIV-1 and wraps. `tick` is 1 when count == DIV-1. The count clears on every entry to RUN.
- State machine, with `state_o` encoding HALT=00, RUN=01, STEP=10, BRK=11:
  - HALT is the state after reset.
  - HALT -> RUN when synchronized run = 1.
  - HALT -> STEP on `step_p` when synchronized run = 0.
  - RUN -> HALT when synchronized run = 0. This takes priority over `tick`, so no pulse is issued that cycle.
  - RUN, on `tick`:
    - If the breakpoint matches (`brk_en_i` and `pc_i == brk_addr_i`), go to BRK and issue no pulse.
    - Otherwise, pulse `pc_en_o` and stay in RUN.
  - STEP: `pc_en_o` = 1 for exactly this cycle, then go to HALT unconditionally.
  - BRK -> STEP on `step_p`. This executes the breakpoint instruction and leaves BRK.
  - BRK -> HALT when synchronized run = 0.
  - BRK ignores synchronized run = 1.
- Resuming from BRK with run asserted and PC unchanged re-enters BRK at the first tick; this is intended.
- `step_p` in RUN is ignored.
- `retired_o` increments by 1 on every cycle with `pc_en_o` = 1 and wraps from 0xFFFF_FFFF to 0.
- `pc_en_o`, `state_o` and `brk_hit_o` are registered outputs.

## Timing
- Reset values: `pc_en_o` = 0, `state_o` = 00 (HALT), `brk_hit_o` = 0, `retired_o` = 0. Prescaler, debouncer and synchronizers also reset to 0.
- Reset assertion mid-operation forces these values immediately (asynchronous). Release is taken at the next `clk_i` edge.
- `run_i` to state change: 3 cycles (2 synchronizer stages plus the FSM register).
- First RUN pulse occurs DIV cycles after entering RUN. Later pulses follow every DIV cycles.
- Step latency:
  - The debounced level changes after 2 synchronizer cycles plus DEB_CYCLES stable cycles.
  - STEP is entered the next cycle.
  - `pc_en_o` = 1 in that same STEP cycle.
- Button bounces shorter than DEB_CYCLES produce no pulse.
- Holding the button produces exactly one pulse.
- Breakpoint compare is evaluated only on `tick` cycles, using `pc_i` as sampled that cycle.

## Configuration
- `RUN_CTRL_BRK_EN` defined:
  - Breakpoint comparator and BRK state are compiled in.
- `RUN_CTRL_BRK_EN` undefined:
  - `brk_en_i` and `brk_addr_i` are unused.
  - BRK is unreachable.
  - `brk_hit_o` is tied to 0.
  - RUN pulses on every tick.

## Structure
- Shared package `run_ctrl_pkg`:
  - `state_t` 2-bit enum with HALT, RUN, STEP and BRK encodings.
  - Width helper constants derived via `$clog2(DIV)` and `$clog2(DEB_CYCLES)`.
- Sub-module `btn_debounce`: parameter DEB_CYCLES, ports `clk_i`, `rst_ni`, `btn_i`, `rise_o`. It contains the synchronizer, stable-level counter and edge detector, and is reusable for other board buttons.

## Test plan
All scenarios use DIV=4 and DEB_CYCLES=3.
- Reset then `run_i`=1 held: `state_o`=01 three cycles later; `pc_en_o` pulses every 4 cycles; `retired_o`=5 after 5 pulses.
- `run_i`=0, one clean `step_i` press held 10 cycles: exactly one `pc_en_o` pulse, 6 cycles after the rising edge; `state_o` passes 00 -> 10 -> 00; `retired_o`=1.
- Step button bouncing with 1-cycle and 2-cycle glitches, then stable high: exactly one pulse.
- `brk_en_i`=1, `brk_addr_i`=0x8, model PC +4 per pulse, `run_i`=1: pulses at PC 0x0 and 0x4, then BRK with `brk_hit_o`=1 and no further pulses. A step press gives one pulse with PC 0x8 and state HALT.
- `rst_ni` pulled low during RUN between ticks: all outputs drop to their reset values immediately. After release with `run_i`=1, the first pulse comes DIV cycles after re-entering RUN.
- With `RUN_CTRL_BRK_EN` undefined, the same breakpoint scenario runs through 0x8 without halting, and `brk_hit_o` stays 0.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and width helpers for the run-control sequencer.
//   state_t     - FSM state, encoding is visible on state_o (LEDs).
//   cnt_w()     - counter width for a modulus n, never narrower than 1 bit.
//   *_DEFAULT   - board defaults for the prescaler / debounce lengths and
//                 the counter widths they imply.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    BRK  = 2'b11
  } state_t;

  localparam int DIV_DEFAULT   = 50_000_000;
  localparam int DEB_DEFAULT   = 1_000_000;
  localparam int DIV_W_DEFAULT = $clog2(DIV_DEFAULT);
  localparam int DEB_W_DEFAULT = $clog2(DEB_DEFAULT);

  // Width of a counter that has to hold 0..n-1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl_if: bundle between the run-control sequencer and the board/core.
//   slave  - the sequencer: takes the switch/button/breakpoint/PC inputs,
//            drives pc_en_o, state_o, brk_hit_o, retired_o.
//   master - the board/core side, the mirror image.
// Signal names keep the sequencer's _i/_o view on both modports.
interface run_ctrl_if;
  logic        run_i;
  logic        step_i;
  logic        brk_en_i;
  logic [31:0] brk_addr_i;
  logic [31:0] pc_i;
  logic        pc_en_o;
  logic [1:0]  state_o;
  logic        brk_hit_o;
  logic [31:0] retired_o;

  modport slave (
    input  run_i, step_i, brk_en_i, brk_addr_i, pc_i,
    output pc_en_o, state_o, brk_hit_o, retired_o
  );

  modport master (
    output run_i, step_i, brk_en_i, brk_addr_i, pc_i,
    input  pc_en_o, state_o, brk_hit_o, retired_o
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: push-button conditioner, reusable for any board button.
//   clk_i   board clock
//   rst_ni  async active-low reset
//   btn_i   raw asynchronous button level
//   rise_o  one-cycle pulse when the debounced level goes 0 -> 1
// The level is first passed through a 2-FF synchronizer. The debounced level
// only follows once the synchronized input has disagreed with it for
// DEB_CYCLES consecutive cycles; any agreeing cycle restarts the count, so
// shorter bounces are swallowed and a held button gives exactly one rise.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);
  import run_ctrl_pkg::*;

  localparam int            CW      = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          lvl_prev_q;

  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync_q[1] != lvl_q) begin
      // Last disagreeing cycle of the window: accept the new level.
      if (cnt_q == CNT_MAX) lvl_d = sync_q[1];
      else                  cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_i};
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
    end
  end

  assign rise_o = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: run-control sequencer for the single-cycle core.
// Instead of a divided clock it issues a one-cycle enable, pc_en_o, so the
// PC and all datapath state stay on the board clock.
//   clk_i, rst_ni        board clock, async active-low reset
//   bus.run_i            run switch (async), 1 = free-run
//   bus.step_i           raw step button (async, active-high)
//   bus.brk_en_i/addr_i  PC breakpoint (quasi-static)
//   bus.pc_i             current PC
//   bus.pc_en_o          registered one-cycle PC-update enable
//   bus.state_o          registered FSM state (HALT/RUN/STEP/BRK)
//   bus.brk_hit_o        registered, 1 while in BRK
//   bus.retired_o        pc_en_o pulses since reset, wraps at 2^32
// Build option: define RUN_CTRL_BRK_EN to compile in the breakpoint
// comparator and BRK state; without it the breakpoint inputs are ignored,
// BRK is unreachable and brk_hit_o stays 0.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DIV        = DIV_DEFAULT,  // cycles per instruction in RUN, >= 2
  parameter int DEB_CYCLES = DEB_DEFAULT   // stable cycles to accept a button level
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  run_ctrl_if.slave   bus
);

  localparam int            DW      = cnt_w(DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

  state_t        state_q, state_d;
  logic [1:0]    run_sync_q;
  logic          run_s;
  logic          step_p;
  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic          brk_match;
  logic          pc_en_q, pc_en_d;
  logic          brk_hit_q, brk_hit_d;
  logic [31:0]   retired_q, retired_d;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) run_sync_q <= '0;
    else         run_sync_q <= {run_sync_q[0], bus.run_i};
  end

  assign run_s = run_sync_q[1];

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_step_deb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_i  (bus.step_i),
    .rise_o (step_p)
  );

  // ---------------------------------------------------------------------------
  // Prescaler. Held at 0 outside RUN, so every entry to RUN starts a fresh
  // DIV-cycle period and the first pulse lands DIV cycles after entry.
  // ---------------------------------------------------------------------------
  assign tick = (state_q == RUN) && (div_q == DIV_MAX);

  always_comb begin
    if (state_q != RUN || tick) div_d = '0;
    else                        div_d = div_q + DW'(1);
  end

  // ---------------------------------------------------------------------------
  // Breakpoint comparator, only consulted on tick cycles.
  // ---------------------------------------------------------------------------
`ifdef RUN_CTRL_BRK_EN
  assign brk_match = bus.brk_en_i && (bus.pc_i == bus.brk_addr_i);
`else
  logic unused_brk;
  assign unused_brk = ^{bus.brk_en_i, bus.brk_addr_i, bus.pc_i};
  assign brk_match  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= HALT;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALT: begin
        if (run_s)       state_d = RUN;
        else if (step_p) state_d = STEP;
      end
      RUN: begin
        // Switch-off wins over a coincident tick.
        if (!run_s)                state_d = HALT;
        else if (tick && brk_match) state_d = BRK;
      end
      STEP: state_d = HALT;
      BRK: begin
        // A step executes the breakpoint instruction; run=1 alone cannot
        // leave BRK.
        if (step_p)      state_d = STEP;
        else if (!run_s) state_d = HALT;
      end
      default: state_d = HALT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Computed from the transition so the registered pulse lines
  // up with the cycle the FSM sits in STEP, or the cycle after a RUN tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en_d   = (state_d == STEP) ||
                ((state_q == RUN) && run_s && tick && !brk_match);
    brk_hit_d = (state_d == BRK);
    retired_d = retired_q + 32'(pc_en_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q     <= '0;
      pc_en_q   <= 1'b0;
      brk_hit_q <= 1'b0;
      retired_q <= '0;
    end else begin
      div_q     <= div_d;
      pc_en_q   <= pc_en_d;
      brk_hit_q <= brk_hit_d;
      retired_q <= retired_d;
    end
  end

  assign bus.pc_en_o   = pc_en_q;
  assign bus.state_o   = state_q;
  assign bus.brk_hit_o = brk_hit_q;
  assign bus.retired_o = retired_q;

endmodule
